// File: rtl/tcm_mem_lat.sv
// rtl/tcm_mem_lat.sv - dual-port TCM simulation model with fixed response latency,
// range errors and LFSR-driven accept stalls
module tcm_mem_lat #(
  parameter int          SIZE_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR  = 32'h80000000,
  parameter int          I_LATENCY  = 1,
  parameter int          D_LATENCY  = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);
  localparam int AW = $clog2(SIZE_BYTES);

  logic [7:0]  r_mem [SIZE_BYTES];
  logic [15:0] r_lfsr;

  logic        r_i_vld [I_LATENCY];
  logic        r_i_err [I_LATENCY];
  logic [63:0] r_i_dat [I_LATENCY];
  logic        r_d_vld [D_LATENCY];
  logic        r_d_err [D_LATENCY];
  logic [31:0] r_d_dat [D_LATENCY];
  logic [10:0] r_d_tag [D_LATENCY];

  logic [31:0]   w_i_off;
  logic          w_i_in;
  logic          w_i_take;
  logic [63:0]   w_i_rdata;
  logic [31:0]   w_d_off;
  logic          w_d_in;
  logic          w_d_access;
  logic          w_d_take;
  logic [AW-1:0] w_d_base;
  logic [31:0]   w_d_merged;
  logic          w_unused;

  assign w_unused = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i};

  // Image load from the bench; bypasses all port timing.
  task write(input logic [31:0] offset, input logic [7:0] value);
    r_mem[offset[AW-1:0]] <= value;
  endtask

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  assign mem_i_accept_o = ~rst_i & (STALL_EN ? r_lfsr[0] : 1'b1);
  assign mem_d_accept_o = ~rst_i & (STALL_EN ? r_lfsr[8] : 1'b1);

  assign w_i_off  = mem_i_pc_i - BASE_ADDR;
  assign w_i_in   = w_i_off < 32'(SIZE_BYTES);
  assign w_i_take = mem_i_rd_i & mem_i_accept_o;

  always_comb begin
    w_i_rdata = '0;
    for (int b = 0; b < 8; b++)
      w_i_rdata[8*b +: 8] = r_mem[(w_i_off[AW-1:0] & ~AW'(7)) | AW'(b)];
  end

  assign w_d_off    = mem_d_addr_i - BASE_ADDR;
  assign w_d_in     = w_d_off < 32'(SIZE_BYTES);
  assign w_d_access = mem_d_rd_i | (|mem_d_wr_i);
  assign w_d_take   = (w_d_access | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i)
                      & mem_d_accept_o;
  assign w_d_base   = w_d_off[AW-1:0] & ~AW'(3);

  // Read data reflects this request's own byte writes (write-then-read-new).
  always_comb begin
    w_d_merged = '0;
    for (int n = 0; n < 4; n++)
      w_d_merged[8*n +: 8] = mem_d_wr_i[n] ? mem_d_data_wr_i[8*n +: 8]
                                           : r_mem[w_d_base | AW'(n)];
  end

  always @(posedge clk_i) begin
    if (w_d_take && w_d_in) begin
      for (int n = 0; n < 4; n++)
        if (mem_d_wr_i[n]) r_mem[w_d_base | AW'(n)] <= mem_d_data_wr_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < I_LATENCY; k++) begin
        r_i_vld[k] <= 1'b0;
        r_i_err[k] <= 1'b0;
        r_i_dat[k] <= '0;
      end
    end else begin
      r_i_vld[0] <= w_i_take;
      r_i_err[0] <= w_i_take & ~w_i_in;
      r_i_dat[0] <= (w_i_take && w_i_in) ? w_i_rdata : '0;
      for (int k = 1; k < I_LATENCY; k++) begin
        r_i_vld[k] <= r_i_vld[k-1];
        r_i_err[k] <= r_i_err[k-1];
        r_i_dat[k] <= r_i_dat[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < D_LATENCY; k++) begin
        r_d_vld[k] <= 1'b0;
        r_d_err[k] <= 1'b0;
        r_d_dat[k] <= '0;
        r_d_tag[k] <= '0;
      end
    end else begin
      r_d_vld[0] <= w_d_take;
      r_d_err[0] <= w_d_take & w_d_access & ~w_d_in;
      r_d_dat[0] <= (w_d_take && w_d_in && mem_d_rd_i) ? w_d_merged : '0;
      r_d_tag[0] <= w_d_take ? mem_d_req_tag_i : '0;
      for (int k = 1; k < D_LATENCY; k++) begin
        r_d_vld[k] <= r_d_vld[k-1];
        r_d_err[k] <= r_d_err[k-1];
        r_d_dat[k] <= r_d_dat[k-1];
        r_d_tag[k] <= r_d_tag[k-1];
      end
    end
  end

  assign mem_i_valid_o    = r_i_vld[I_LATENCY-1];
  assign mem_i_error_o    = r_i_err[I_LATENCY-1];
  assign mem_i_inst_o     = r_i_dat[I_LATENCY-1];
  assign mem_d_ack_o      = r_d_vld[D_LATENCY-1];
  assign mem_d_error_o    = r_d_err[D_LATENCY-1];
  assign mem_d_data_rd_o  = r_d_dat[D_LATENCY-1];
  assign mem_d_resp_tag_o = r_d_tag[D_LATENCY-1];
endmodule

// File: doc/tcm_mem_lat.md
Name: tcm_mem_lat

Overview:
- Parametrised successor to the fixed single-cycle TCM model used in the core benches.
- Dual-port memory: a 64-bit instruction fetch port and a 32-bit tagged data port, both attached directly to riscv_core.
- Adds configurable base/size, per-port fixed response latency, address-range error responses, and LFSR-driven accept stalls to stress core handshakes.
- Used as the memory model in simulation benches; not intended for synthesis.

Parameters:
- SIZE_BYTES, 65536: memory size; power of two, minimum 8.
- BASE_ADDR, 32'h80000000: first byte address; aligned to SIZE_BYTES.
- I_LATENCY, 1: cycles from fetch accept to mem_i_valid_o; range 1..8.
- D_LATENCY, 1: cycles from data accept to mem_d_ack_o; range 1..8.
- STALL_EN, 0: 1 enables pseudo-random accept throttling.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mem_i_rd_i  in  1  fetch request
- mem_i_flush_i  in  1  fetch-side flush; no-op
- mem_i_invalidate_i  in  1  fetch-side invalidate; no-op
- mem_i_pc_i  in  32  fetch address; bits [2:0] ignored
- mem_i_accept_o  out  1  fetch request accepted this cycle
- mem_i_valid_o  out  1  fetch response valid
- mem_i_error_o  out  1  fetch response error
- mem_i_inst_o  out  64  fetch data; little-endian, 8-byte aligned
- mem_d_addr_i  in  32  data address; bits [1:0] ignored
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte write enables
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag
- mem_d_invalidate_i  in  1  cache maintenance op
- mem_d_writeback_i  in  1  cache maintenance op
- mem_d_flush_i  in  1  cache maintenance op
- mem_d_data_rd_o  out  32  read data
- mem_d_accept_o  out  1  data request accepted
- mem_d_ack_o  out  1  data response valid
- mem_d_error_o  out  1  data response error
- mem_d_resp_tag_o  out  11  tag returned with the response

Behaviour:
- Reset:
  - All outputs 0; latency pipes cleared; LFSR = LFSR_SEED.
  - Memory array not reset; contents survive reset.
  - Responses in flight when rst_i asserts are discarded, never delivered.
  - Accept outputs forced 0 while rst_i is high.
- Backdoor task write(offset, byte) writes array[offset] directly, with no timing. Used for image load.
- Range check:
  - off = addr - BASE_ADDR (32-bit wrap); in-range iff off < SIZE_BYTES.
  - Out-of-range request: still accepted; no array write; response carries error=1, data=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle out of reset.
  - STALL_EN=0: mem_i_accept_o = mem_d_accept_o = 1 (outside reset).
  - STALL_EN=1: mem_i_accept_o = lfsr[0]; mem_d_accept_o = lfsr[8]. Both are combinational from the register, independent of request inputs.
- Fetch port:
  - Request is taken when mem_i_rd_i & mem_i_accept_o.
  - Array read at accept: 8 bytes at off & ~7.
  - Data, error and a valid bit enter a shift pipe of depth I_LATENCY; mem_i_valid_o is asserted exactly I_LATENCY cycles after the accept edge.
  - Back-to-back accepts give back-to-back valids, in order.
  - flush/invalidate are no-ops: in-flight responses are still delivered.
- Data port:
  - Request is taken when (mem_d_rd_i | (|mem_d_wr_i) | invalidate | writeback | flush) & mem_d_accept_o.
  - Write: bytes with wr[n]=1 written to off&~3 + n at the accept edge. Response has data_rd=0.
  - Read: word captured at the accept edge, after any same-cycle write from the same request. rd together with wr gives write-then-read-new.
  - Maintenance ops: no array effect; ack with error=0.
  - mem_d_ack_o is asserted D_LATENCY cycles after accept with resp_tag = req_tag.
  - Responses are in order, one per accepted request.
- Port collision:
  - A fetch and a data write to the same bytes in the same cycle: the fetch returns the old data (read-before-write).
  - A data write is visible to any fetch accepted on a later cycle.
- No response backpressure exists. With a fixed-latency pipe, the number of outstanding requests per port is at most its LATENCY.

Test Plan:
- I_LATENCY=1, D_LATENCY=1, STALL_EN=0:
  - Backdoor-load bytes 0x00..0x07 at offset 0; fetch pc=0x80000004.
  - -> next cycle valid=1, inst=64'h0706050403020100, error=0.
- D_LATENCY=3:
  - Write 0xDEADBEEF, wr=4'b0101, tag=0x155 at 0x80000010 over old 0x11223344; then read with tag=0x2AA on the next cycle.
  - -> ack at +3 with tag 0x155; ack at +4 with data 0x11AD33EF, tag 0x2AA.
- Out-of-range read at 0x7FFFFFFC and fetch at 0x80010000 (SIZE_BYTES=65536).
  - -> error=1, data=0; array unchanged.
- STALL_EN=1, LFSR_SEED=16'hACE1, mem_d_rd_i held high for 64 cycles.
  - -> accept pattern matches a reference LFSR model; acks equal the number of accepts, each D_LATENCY later.
- Reset mid-operation:
  - Issue 3 reads at D_LATENCY=4, then assert rst_i asynchronously one cycle later.
  - -> no ack is ever produced; outputs drop to 0 immediately; memory contents unchanged after release.
- Same-cycle fetch and write to offset 0x20:
  - -> fetch returns old data; a fetch one cycle later returns the new data.
